fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register that produces the instruction stream consumed by the decode stage. It owns the program counter, drives the instruction-memory read address, and assembles two-word (opcode + 16-bit immediate) instructions. It also honours the stall, flush and branch-redirect requests issued by the hazard and execute logic. Its outputs are registered, and they feed the decode stage's opcode, register-field and immediate inputs directly.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `NOP`, default 16'h0000: instruction word inserted on reset, flush or bubble.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: hold the PC, the FSM and all outputs.
- `flush` in 1: squash the IF/ID contents.
- `branch_taken` in 1: redirect fetch to `branch_target`; implies flush.
- `branch_target` in 16: redirect address.
- `imem_addr` out 16: instruction-memory read address; combinational, equal to PC.
- `imem_data` in 16: word at `imem_addr`; combinational read, valid in the same cycle.
- `instr_out` out 16: registered opcode word sent to decode.
- `imm_out` out 16: registered immediate word; 16'h0000 for single-word instructions.
- `pc_out` out 16: registered address of the opcode word in `instr_out`.
- `valid_out` out 1: `instr_out`/`imm_out` hold a real instruction; 0 means bubble.

## Operation
- An opcode word with `imem_data[15:14]==2'b11` carries an immediate in the next word. Any other value is a single-word instruction.
- FSM states: FETCH_OP and FETCH_IMM.
- FETCH_OP with a single-word instruction:
  - `instr_out<=imem_data`, `imm_out<=0`, `pc_out<=PC`, `valid_out<=1`, `PC<=PC+1`.
- FETCH_OP with a two-word opcode:
  - `op_hold<=imem_data`, `op_pc<=PC`, `PC<=PC+1`.
  - `instr_out<=NOP`, `valid_out<=0`.
  - Next state is FETCH_IMM.
- FETCH_IMM:
  - `instr_out<=op_hold`, `imm_out<=imem_data`, `pc_out<=op_pc`, `valid_out<=1`, `PC<=PC+1`.
  - Next state is FETCH_OP.
- PC arithmetic is modulo 2^16. 16'hFFFF+1 wraps to 16'h0000, including between the opcode and immediate words.
- Priority: `rst` > `branch_taken` > `flush` > `stall` > normal fetch.
- On `branch_taken`:
  - `PC<=branch_target`, `instr_out<=NOP`, `imm_out<=0`, `valid_out<=0`, state to FETCH_OP.
  - This applies even when `stall` is asserted.
- On `flush` without `branch_taken`:
  - IF/ID is cleared as for a branch and the state goes to FETCH_OP.
  - If the stage was in FETCH_IMM, `PC<=op_pc` so the half-fetched instruction is refetched. Otherwise PC is unchanged.
- On `stall`: PC, state, `op_hold`, `op_pc` and all outputs keep their values. `imem_addr` keeps presenting the same PC.

## Timing
- Reset values:
  - PC=`RESET_PC`, state FETCH_OP.
  - `instr_out`=`NOP`, `imm_out`=0, `pc_out`=0, `valid_out`=0.
  - `imem_addr`=`RESET_PC` during and after reset.
- Latency: a word presented at cycle N appears on the outputs after edge N.
- Single-word throughput is one instruction per cycle. A two-word instruction takes 2 cycles and emits exactly one bubble before it.
- `rst` asserted mid-FETCH_IMM discards `op_hold`. No partial instruction is ever emitted.
- `stall` and `flush` arriving together: flush wins, with no stall effect that cycle.

## Configuration
- `FETCH_IMM_EN` defined: the two-word immediate support described above is compiled in.
- `FETCH_IMM_EN` undefined:
  - FETCH_IMM, `op_hold` and `op_pc` are absent. Every word is a single-word instruction regardless of bits [15:14].
  - `imm_out` is constant 16'h0000.
  - `flush` never rewinds the PC.

## Test plan
- Reset then release, memory holding 16'h1234, 16'h2345 at addresses 0 and 1:
  - Cycle 1 gives `instr_out`=16'h1234, `pc_out`=0, `valid_out`=1.
  - Cycle 2 gives 16'h2345, `pc_out`=1.
- Two-word instruction, 16'hC100 at address 2 and 16'hBEEF at address 3:
  - One bubble (`valid_out`=0), then `instr_out`=16'hC100, `imm_out`=16'hBEEF, `pc_out`=2.
  - Next fetch is at address 4.
- `stall` held 3 cycles mid-stream: outputs and `imem_addr` are frozen for 3 cycles, then resume with no skipped or duplicated instruction.
- `branch_taken`=1 with `branch_target`=16'h0040 while `stall`=1:
  - Next cycle `valid_out`=0 and `imem_addr`=16'h0040.
  - The following cycle shows the word at 16'h0040 with `pc_out`=16'h0040.
- `flush` in FETCH_IMM for an opcode at 16'h0010: `valid_out`=0, PC rewinds to 16'h0010, and the instruction is refetched and emitted complete.
- Wrap-around, PC=16'hFFFF holding two-word opcode 16'hC000 with its immediate at 16'h0000: `imm_out`=word[0], `pc_out`=16'hFFFF, next PC 16'h0001.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/execute control, instruction-memory port and IF/ID outputs.
// master = fetch stage, slave = decode/hazard/memory side.
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instr_out;
  logic [15:0] imm_out;
  logic [15:0] pc_out;
  logic        valid_out;

  modport master (
    input  stall, flush, branch_taken, branch_target, imem_data,
    output imem_addr, instr_out, imm_out, pc_out, valid_out
  );

  modport slave (
    output stall, flush, branch_taken, branch_target, imem_data,
    input  imem_addr, instr_out, imm_out, pc_out, valid_out
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register; FETCH_IMM_EN compiles in two-word
// (opcode + 16-bit immediate) instruction assembly, otherwise every word is single-word.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP      = 16'h0000
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  logic [15:0] r_pc,     w_pc_nxt;
  logic [15:0] r_instr,  w_instr_nxt;
  logic [15:0] r_pc_out, w_pc_out_nxt;
  logic        r_valid,  w_valid_nxt;

`ifdef FETCH_IMM_EN
  typedef enum logic {FETCH_OP, FETCH_IMM} state_t;
  state_t      r_state,   w_state_nxt;
  logic [15:0] r_op_hold, w_op_hold_nxt;
  logic [15:0] r_op_pc,   w_op_pc_nxt;
  logic [15:0] r_imm,     w_imm_nxt;
`endif

  always_comb begin
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    w_pc_out_nxt = r_pc_out;
    w_valid_nxt  = r_valid;
`ifdef FETCH_IMM_EN
    w_state_nxt   = r_state;
    w_op_hold_nxt = r_op_hold;
    w_op_pc_nxt   = r_op_pc;
    w_imm_nxt     = r_imm;
`endif
    if (bus.branch_taken || bus.flush) begin
      w_instr_nxt = NOP;
      w_valid_nxt = 1'b0;
`ifdef FETCH_IMM_EN
      w_imm_nxt   = '0;
      w_state_nxt = FETCH_OP;
      // A flush mid-instruction rewinds so the opcode word is fetched again.
      if (!bus.branch_taken && r_state == FETCH_IMM)
        w_pc_nxt = r_op_pc;
`endif
      if (bus.branch_taken)
        w_pc_nxt = bus.branch_target;
    end else if (!bus.stall) begin
      w_pc_nxt = r_pc + 16'd1;
`ifdef FETCH_IMM_EN
      if (r_state == FETCH_IMM) begin
        w_instr_nxt  = r_op_hold;
        w_imm_nxt    = bus.imem_data;
        w_pc_out_nxt = r_op_pc;
        w_valid_nxt  = 1'b1;
        w_state_nxt  = FETCH_OP;
      end else if (bus.imem_data[15:14] == 2'b11) begin
        w_op_hold_nxt = bus.imem_data;
        w_op_pc_nxt   = r_pc;
        w_instr_nxt   = NOP;
        w_imm_nxt     = '0;
        w_valid_nxt   = 1'b0;
        w_state_nxt   = FETCH_IMM;
      end else begin
        w_imm_nxt = '0;
`else
      begin
`endif
        w_instr_nxt  = bus.imem_data;
        w_pc_out_nxt = r_pc;
        w_valid_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_instr  <= NOP;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
`ifdef FETCH_IMM_EN
      r_state   <= FETCH_OP;
      r_op_hold <= '0;
      r_op_pc   <= '0;
      r_imm     <= '0;
`endif
    end else begin
      r_pc     <= w_pc_nxt;
      r_instr  <= w_instr_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_valid  <= w_valid_nxt;
`ifdef FETCH_IMM_EN
      r_state   <= w_state_nxt;
      r_op_hold <= w_op_hold_nxt;
      r_op_pc   <= w_op_pc_nxt;
      r_imm     <= w_imm_nxt;
`endif
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.instr_out = r_instr;
  assign bus.pc_out    = r_pc_out;
  assign bus.valid_out = r_valid;
`ifdef FETCH_IMM_EN
  assign bus.imm_out   = r_imm;
`else
  assign bus.imm_out   = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan steps followed by random
// stall/flush/branch/reset traffic, checked against an instruction-stream model.
module tb_fetch_stage;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [15:0] NOP_W  = 16'h0F00;
`ifdef FETCH_IMM_EN
  localparam bit IMM_EN = 1'b1;
`else
  localparam bit IMM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus_if ();

  fetch_stage #(.RESET_PC(RST_PC), .NOP(NOP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [15:0] mem [0:65535];
  assign bus_if.imem_data = mem[bus_if.imem_addr];

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Model: program counter, an optional half-assembled instruction, expected IF/ID.
  logic [15:0] m_pc, m_op, m_op_pc;
  bit          m_pend;
  logic [15:0] e_instr, e_imm, e_pc_out;
  bit          e_valid, e_full;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit st, input bit fl, input bit br,
                            input logic [15:0] tgt);
    logic [15:0] w;
    w = mem[m_pc];
    e_full = 1'b0;
    if (r) begin
      m_pc = RST_PC; m_pend = 1'b0;
      e_instr = NOP_W; e_imm = 16'h0000; e_pc_out = 16'h0000; e_valid = 1'b0; e_full = 1'b1;
    end else if (br || fl) begin
      if (br) m_pc = tgt;
      else if (m_pend) m_pc = m_op_pc;
      m_pend = 1'b0; e_instr = NOP_W; e_valid = 1'b0;
    end else if (st) begin
      // everything holds
    end else if (m_pend) begin
      e_instr = m_op; e_imm = w; e_pc_out = m_op_pc; e_valid = 1'b1;
      m_pend = 1'b0; m_pc = m_pc + 16'd1;
    end else if (IMM_EN && w[15:14] == 2'b11) begin
      m_op = w; m_op_pc = m_pc; m_pend = 1'b1; m_pc = m_pc + 16'd1;
      e_instr = NOP_W; e_valid = 1'b0;
    end else begin
      e_instr = w; e_imm = 16'h0000; e_pc_out = m_pc; e_valid = 1'b1;
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic step(input string tag, input bit r, input bit st, input bit fl,
                      input bit br, input logic [15:0] tgt);
    rst                  = r;
    bus_if.stall         = st;
    bus_if.flush         = fl;
    bus_if.branch_taken  = br;
    bus_if.branch_target = tgt;
    model_edge(r, st, fl, br, tgt);
    @(posedge clk);
    #1;
    check($sformatf("%s.addr", tag), bus_if.imem_addr, m_pc);
    check($sformatf("%s.valid", tag), 16'(bus_if.valid_out), 16'(e_valid));
    check($sformatf("%s.instr", tag), bus_if.instr_out, e_instr);
    if (e_valid || e_full) begin
      check($sformatf("%s.imm", tag), bus_if.imm_out, e_imm);
      check($sformatf("%s.pc_out", tag), bus_if.pc_out, e_pc_out);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h2345;
    mem[16'h0002] = 16'hC100;
    mem[16'h0003] = 16'hBEEF;
    mem[16'h0004] = 16'h0444;
    mem[16'h0005] = 16'h1555;
    mem[16'h0006] = 16'h2666;
    mem[16'h0007] = 16'h3777;
    mem[16'h0010] = 16'hC0AA;
    mem[16'h0011] = 16'h5A5A;
    mem[16'h0012] = 16'h0012;
    mem[16'h0040] = 16'h4040;
    mem[16'h0041] = 16'h4141;
    mem[16'hFFFF] = 16'hC000;

    rst = 1'b1; bus_if.stall = 1'b0; bus_if.flush = 1'b0;
    bus_if.branch_taken = 1'b0; bus_if.branch_target = 16'h0000;

    // Reset and the opening single-word instructions
    step("rst0", 1, 0, 0, 0, 16'h0);
    step("rst1", 1, 0, 0, 0, 16'h0);
    step("op0", 0, 0, 0, 0, 16'h0);
    step("op1", 0, 0, 0, 0, 16'h0);
    // Two-word instruction at 2/3, then continue at 4
    step("two_a", 0, 0, 0, 0, 16'h0);
    step("two_b", 0, 0, 0, 0, 16'h0);
    step("op4", 0, 0, 0, 0, 16'h0);
    // Three-cycle stall mid-stream
    step("stall0", 0, 1, 0, 0, 16'h0);
    step("stall1", 0, 1, 0, 0, 16'h0);
    step("stall2", 0, 1, 0, 0, 16'h0);
    step("resume5", 0, 0, 0, 0, 16'h0);
    step("resume6", 0, 0, 0, 0, 16'h0);
    // Branch wins over stall
    step("br_st", 0, 1, 0, 1, 16'h0040);
    step("br_tgt", 0, 0, 0, 0, 16'h0);
    step("br_next", 0, 0, 0, 0, 16'h0);
    // Flush while the immediate of the opcode at 0x10 is pending
    step("to10", 0, 0, 0, 1, 16'h0010);
    step("op10", 0, 0, 0, 0, 16'h0);
    step("flush", 0, 0, 1, 0, 16'h0);
    step("refetch_a", 0, 0, 0, 0, 16'h0);
    step("refetch_b", 0, 0, 0, 0, 16'h0);
    step("after", 0, 0, 0, 0, 16'h0);
    // Flush and stall together: flush takes effect
    step("fl_st", 0, 1, 1, 0, 16'h0);
    step("fl_st_n", 0, 0, 0, 0, 16'h0);
    // Wrap-around across 0xFFFF -> 0x0000
    step("toFFFF", 0, 0, 0, 1, 16'hFFFF);
    step("wrap_a", 0, 0, 0, 0, 16'h0);
    step("wrap_b", 0, 0, 0, 0, 16'h0);
    step("wrap_c", 0, 0, 0, 0, 16'h0);
    // Reset while an immediate is pending discards the opcode
    step("to10b", 0, 0, 0, 1, 16'h0010);
    step("op10b", 0, 0, 0, 0, 16'h0);
    step("rst_mid", 1, 0, 0, 0, 16'h0);
    step("post_rst", 0, 0, 0, 0, 16'h0);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      bit r, st, fl, br;
      logic [15:0] tgt;
      r  = ($urandom_range(0, 59) == 0);
      br = ($urandom_range(0, 11) == 0);
      fl = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 4) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1)) : 16'($urandom);
      step($sformatf("rnd%0d", n), r, st, fl, br, tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
